// File: rtl/ct_fcnvt_wb_buf.sv
// ct_fcnvt_wb_buf: write-back buffer for the FP convert pipe; formats EX3 results and
// drains them in order to the regfile arbiter. Optional same-cycle bypass: CT_FCNVT_WB_BYPASS_EN.
`default_nettype none

module ct_fcnvt_wb_buf #(
    parameter int DEPTH  = 2,
    parameter int PREG_W = 7
) (
    input  logic              ex1_pipe_clk,
    input  logic              cpurst_b,
    input  logic              fcnvt_forward_r_vld,
    input  logic [63:0]       fcnvt_forward_result,
    input  logic              fcnvt_ereg_forward_r_vld,
    input  logic [4:0]        fcnvt_ereg_forward_result,
    input  logic              ex3_dest_float,
    input  logic              ex3_dest_half,
    input  logic              ex3_dest_single,
    input  logic              ex3_dest_double,
    input  logic              ex3_dest_l16,
    input  logic              ex3_dest_l32,
    input  logic              ex3_dest_l64,
    input  logic [PREG_W-1:0] ex3_preg,
    input  logic              rtu_yy_xx_flush,
    input  logic              wb_grant,
    output logic              fcnvt_wb_full,
    output logic              wb_vld,
    output logic [63:0]       wb_data,
    output logic [PREG_W-1:0] wb_preg,
    output logic              wb_float,
    output logic              wb_fflags_vld,
    output logic [4:0]        wb_fflags
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [63:0]       data_mem  [DEPTH];
    logic [PREG_W-1:0] preg_mem  [DEPTH];
    logic              float_mem [DEPTH];
    logic [4:0]        flag_mem  [DEPTH];

    logic [AW:0]       rd_ptr, wr_ptr, rd_nxt, wr_nxt, cnt_nxt;
    logic              vld_q, full_q, float_q;
    logic [63:0]       data_q, fmt_data, head_data;
    logic [PREG_W-1:0] preg_q, head_preg;
    logic [4:0]        flags_q, head_flags;
    logic              head_float;
    logic              push, pop, byp_take;

    // The default cases pass the raw result through (double / l64).
    logic unused_tags;
    assign unused_tags = fcnvt_ereg_forward_r_vld ^ ex3_dest_double ^ ex3_dest_l64;

    always_comb begin
        fmt_data = fcnvt_forward_result;
        if (ex3_dest_float) begin
            if (ex3_dest_half)
                fmt_data = {48'hFFFF_FFFF_FFFF, fcnvt_forward_result[15:0]};
            else if (ex3_dest_single)
                fmt_data = {32'hFFFF_FFFF, fcnvt_forward_result[31:0]};
        end else begin
            if (ex3_dest_l16)
                fmt_data = {{48{fcnvt_forward_result[15]}}, fcnvt_forward_result[15:0]};
            else if (ex3_dest_l32)
                fmt_data = {{32{fcnvt_forward_result[31]}}, fcnvt_forward_result[31:0]};
        end
    end

`ifdef CT_FCNVT_WB_BYPASS_EN
    assign byp_take = !vld_q && fcnvt_forward_r_vld && wb_grant;
`else
    assign byp_take = 1'b0;
`endif

    assign push    = fcnvt_forward_r_vld && !full_q && !rtu_yy_xx_flush && !byp_take;
    assign pop     = vld_q && wb_grant && !rtu_yy_xx_flush;
    assign wr_nxt  = wr_ptr + {{AW{1'b0}}, push};
    assign rd_nxt  = rd_ptr + {{AW{1'b0}}, pop};
    assign cnt_nxt = wr_nxt - rd_nxt;

    // The next head may be the entry being written this very edge.
    always_comb begin
        head_data  = data_mem[rd_nxt[AW-1:0]];
        head_preg  = preg_mem[rd_nxt[AW-1:0]];
        head_float = float_mem[rd_nxt[AW-1:0]];
        head_flags = flag_mem[rd_nxt[AW-1:0]];
        if (push && (rd_nxt == wr_ptr)) begin
            head_data  = fmt_data;
            head_preg  = ex3_preg;
            head_float = ex3_dest_float;
            head_flags = fcnvt_ereg_forward_result;
        end
    end

    always_ff @(posedge ex1_pipe_clk) begin
        if (push) begin
            data_mem[wr_ptr[AW-1:0]]  <= fmt_data;
            preg_mem[wr_ptr[AW-1:0]]  <= ex3_preg;
            float_mem[wr_ptr[AW-1:0]] <= ex3_dest_float;
            flag_mem[wr_ptr[AW-1:0]]  <= fcnvt_ereg_forward_result;
        end
    end

    always_ff @(posedge ex1_pipe_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            vld_q   <= 1'b0;
            full_q  <= 1'b0;
            data_q  <= '0;
            preg_q  <= '0;
            float_q <= 1'b0;
            flags_q <= '0;
        end else if (rtu_yy_xx_flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            vld_q   <= 1'b0;
            full_q  <= 1'b0;
        end else begin
            rd_ptr  <= rd_nxt;
            wr_ptr  <= wr_nxt;
            vld_q   <= (cnt_nxt != '0);
            full_q  <= (cnt_nxt == FULL_CNT);
            if (cnt_nxt != '0) begin
                data_q  <= head_data;
                preg_q  <= head_preg;
                float_q <= head_float;
                flags_q <= head_flags;
            end
        end
    end

`ifdef CT_FCNVT_WB_BYPASS_EN
    assign wb_vld    = vld_q || fcnvt_forward_r_vld;
    assign wb_data   = vld_q ? data_q  : fmt_data;
    assign wb_preg   = vld_q ? preg_q  : ex3_preg;
    assign wb_float  = vld_q ? float_q : ex3_dest_float;
    assign wb_fflags = vld_q ? flags_q : fcnvt_ereg_forward_result;
`else
    assign wb_vld    = vld_q;
    assign wb_data   = data_q;
    assign wb_preg   = preg_q;
    assign wb_float  = float_q;
    assign wb_fflags = flags_q;
`endif

    assign fcnvt_wb_full = full_q;
    assign wb_fflags_vld = wb_vld && wb_grant;

endmodule

`default_nettype wire

// File: tb/tb_ct_fcnvt_wb_buf.sv
// Scoreboard bench for ct_fcnvt_wb_buf (default build, no bypass).
`default_nettype none

module tb_ct_fcnvt_wb_buf;

    localparam int DEPTH  = 2;
    localparam int PREG_W = 7;

    typedef struct {
        logic [63:0]       data;
        logic [PREG_W-1:0] preg;
        logic              flt;
        logic [4:0]        flags;
    } entry_t;

    logic              clk = 1'b0;
    logic              rst_b = 1'b0;
    logic              r_vld = 1'b0, e_vld = 1'b0;
    logic [63:0]       r_res = '0;
    logic [4:0]        e_res = '0;
    logic              d_float = 1'b0, d_half = 1'b0, d_single = 1'b0, d_double = 1'b0;
    logic              d_l16 = 1'b0, d_l32 = 1'b0, d_l64 = 1'b0;
    logic [PREG_W-1:0] preg = '0;
    logic              flush = 1'b0, grant = 1'b0;
    logic              full, vld, o_float, fvld;
    logic [63:0]       data;
    logic [PREG_W-1:0] o_preg;
    logic [4:0]        fflags;

    entry_t exp_q[$];
    int     vis_cnt = 0;
    bit     mon_en  = 1'b0;
    int     n_vec   = 0;
    int     n_fail  = 0;

    ct_fcnvt_wb_buf #(.DEPTH(DEPTH), .PREG_W(PREG_W)) dut (
        .ex1_pipe_clk(clk), .cpurst_b(rst_b),
        .fcnvt_forward_r_vld(r_vld), .fcnvt_forward_result(r_res),
        .fcnvt_ereg_forward_r_vld(e_vld), .fcnvt_ereg_forward_result(e_res),
        .ex3_dest_float(d_float), .ex3_dest_half(d_half), .ex3_dest_single(d_single),
        .ex3_dest_double(d_double), .ex3_dest_l16(d_l16), .ex3_dest_l32(d_l32),
        .ex3_dest_l64(d_l64), .ex3_preg(preg), .rtu_yy_xx_flush(flush), .wb_grant(grant),
        .fcnvt_wb_full(full), .wb_vld(vld), .wb_data(data), .wb_preg(o_preg),
        .wb_float(o_float), .wb_fflags_vld(fvld), .wb_fflags(fflags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // sel: 0 half, 1 single, 2 double, 3 l16, 4 l32, 5 l64
    function automatic logic [63:0] fmt_ref(input logic [63:0] r, input int sel);
        logic [63:0] lo16, lo32;
        lo16 = r & 64'h0000_0000_0000_FFFF;
        lo32 = r & 64'h0000_0000_FFFF_FFFF;
        case (sel)
            0: return lo16 | 64'hFFFF_FFFF_FFFF_0000;
            1: return lo32 | 64'hFFFF_FFFF_0000_0000;
            3: return r[15] ? (lo16 | 64'hFFFF_FFFF_FFFF_0000) : lo16;
            4: return r[31] ? (lo32 | 64'hFFFF_FFFF_0000_0000) : lo32;
            default: return r;
        endcase
    endfunction

    task automatic cycle(input bit v, input logic [63:0] r, input logic [4:0] f, input int sel,
                         input logic [PREG_W-1:0] p, input bit fl, input bit g);
        entry_t e;
        @(negedge clk);
        r_vld = v; e_vld = v; r_res = r; e_res = f; preg = p; flush = fl; grant = g;
        d_float = (sel < 3); d_half = (sel == 0); d_single = (sel == 1); d_double = (sel == 2);
        d_l16 = (sel == 3); d_l32 = (sel == 4); d_l64 = (sel == 5);
        if (v && !fl && vis_cnt < DEPTH) begin
            e.data = fmt_ref(r, sel); e.preg = p; e.flt = (sel < 3); e.flags = f;
            exp_q.push_back(e);
        end else if (v && !fl) begin
            $display("note: protocol error, push while full is dropped at %0t", $time);
        end
    endtask

    task automatic idle(input bit g);
        cycle(1'b0, 64'd0, 5'd0, 2, '0, 1'b0, g);
    endtask

    // Monitor: compares presented head against the scoreboard, then advances the model.
    initial begin
        entry_t h;
        bit     acc;
        forever begin
            @(negedge clk);
            #3;
            if (mon_en) begin
                chk("wb_vld", {63'd0, vld}, {63'd0, vis_cnt != 0});
                chk("full", {63'd0, full}, {63'd0, vis_cnt == DEPTH});
                if (vis_cnt != 0 && vld) begin
                    h = exp_q[0];
                    chk("wb_data", data, h.data);
                    chk("wb_preg", {57'd0, o_preg}, {57'd0, h.preg});
                    chk("wb_float", {63'd0, o_float}, {63'd0, h.flt});
                    chk("wb_fflags", {59'd0, fflags}, {59'd0, h.flags});
                    chk("fflags_vld", {63'd0, fvld}, {63'd0, grant});
                end else begin
                    chk("fflags_vld_idle", {63'd0, fvld}, 64'd0);
                end
                acc = r_vld && !flush && (vis_cnt < DEPTH);
                if (flush) begin
                    exp_q.delete();
                    vis_cnt = 0;
                end else begin
                    if (vis_cnt != 0 && grant) begin
                        void'(exp_q.pop_front());
                        vis_cnt--;
                    end
                    if (acc) vis_cnt++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        rst_b = 1'b1;
        chk("reset_vld", {63'd0, vld}, 64'd0);
        chk("reset_full", {63'd0, full}, 64'd0);
        chk("reset_data", data, 64'd0);
        mon_en = 1'b1;

        // Single-precision NaN-boxing with grant held.
        cycle(1'b1, 64'h0000_0000_3F80_0000, 5'b00001, 1, 7'd5, 1'b0, 1'b1);
        idle(1'b1); #4;
        chk("single_data", data, 64'hFFFF_FFFF_3F80_0000);
        chk("single_float", {63'd0, o_float}, 64'd1);
        idle(1'b1); #4;
        chk("single_fvld_once", {63'd0, fvld}, 64'd0);

        // Integer l32 sign extension with NV flag.
        cycle(1'b1, 64'h1234_5678_8000_0000, 5'b10000, 4, 7'd9, 1'b0, 1'b0);
        idle(1'b0); #4;
        chk("l32_data", data, 64'hFFFF_FFFF_8000_0000);
        chk("l32_flags", {59'd0, fflags}, 64'b10000);
        idle(1'b1);
        idle(1'b1);

        // Three back-to-back pushes into a DEPTH-2 buffer without grant.
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 64'hA000 + 64'(i), 5'(i), 2, 7'(20 + i), 1'b0, 1'b0);
        idle(1'b0); #4;
        chk("full_after_2", {63'd0, full}, 64'd1);
        for (int i = 0; i < 3; i++) idle(1'b1);
        #4;
        chk("full_drained", {63'd0, full}, 64'd0);

        // count=1 then push and grant together.
        cycle(1'b1, 64'h11, 5'd1, 5, 7'd1, 1'b0, 1'b0);
        cycle(1'b1, 64'h22, 5'd2, 5, 7'd2, 1'b0, 1'b1);
        idle(1'b0); #4;
        chk("pushpop_data", data, 64'h22);
        idle(1'b1);

        // Flush with two entries plus a concurrent push.
        cycle(1'b1, 64'h33, 5'd3, 3, 7'd3, 1'b0, 1'b0);
        cycle(1'b1, 64'h44, 5'd4, 3, 7'd4, 1'b0, 1'b0);
        cycle(1'b1, 64'h55, 5'd5, 3, 7'd5, 1'b1, 1'b0);
        idle(1'b1); #4;
        chk("flush_vld", {63'd0, vld}, 64'd0);
        chk("flush_full", {63'd0, full}, 64'd0);
        idle(1'b1);

        // Asynchronous reset while holding an ungranted entry.
        cycle(1'b1, 64'h0000_0000_0000_8001, 5'd7, 3, 7'd66, 1'b0, 1'b0);
        idle(1'b0);
        #5;
        mon_en = 1'b0;
        rst_b  = 1'b0;
        #1;
        chk("arst_vld", {63'd0, vld}, 64'd0);
        chk("arst_full", {63'd0, full}, 64'd0);
        chk("arst_fvld", {63'd0, fvld}, 64'd0);
        chk("arst_data", data, 64'd0);
        chk("arst_preg", {57'd0, o_preg}, 64'd0);
        chk("arst_float", {63'd0, o_float}, 64'd0);
        chk("arst_flags", {59'd0, fflags}, 64'd0);
        exp_q.delete();
        vis_cnt = 0;
        @(negedge clk);
        rst_b  = 1'b1;
        mon_en = 1'b1;
        cycle(1'b1, 64'hDEAD_BEEF_0000_7777, 5'd2, 0, 7'd77, 1'b0, 1'b0);
        idle(1'b1); #4;
        chk("post_rst_vld", {63'd0, vld}, 64'd1);
        chk("post_rst_data", data, 64'hFFFF_FFFF_FFFF_7777);

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 1) == 1),
                  {$urandom, $urandom},
                  5'($urandom_range(0, 31)),
                  int'($urandom_range(0, 5)),
                  7'($urandom_range(0, 127)),
                  ($urandom_range(0, 29) == 0),
                  ($urandom_range(0, 2) != 0));
        end
        for (int i = 0; i < 4; i++) idle(1'b1);
        #4;
        chk("final_empty", {63'd0, vld}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
